config_bus_receiver: RTL and testbench
======================================

# config_bus_receiver

Receives the raw configuration stream that the CGRA top level sees on `config_addr_in`/`config_data_in`, one word per clock with no source backpressure, and forwards it to the tile fabric. The block registers and decodes each word into tile/feature/register fields and buffers it in a small FIFO. Words are handed to the fabric over a valid/ready handshake. It also detects end-of-configuration and reports buffer overflow. It sits directly behind the top-level config pins, ahead of the per-tile configuration decoders.

## Interface
- `FIFO_DEPTH`, 4: number of buffered config words; power of two, ≥2
- `IDLE_TIMEOUT`, 8: consecutive no-op cycles after the last write before config is declared done; ≥1
- `clk_in` in 1: single clock; all logic on its rising edge
- `reset_in` in 1: synchronous, active-high reset
- `config_addr_in` in 32: config address; value 0 is a reserved no-op; fields are [15:0] tile, [23:16] feature, [31:24] register
- `config_data_in` in 32: config data; ignored when address is 0
- `cfg_valid_out` out 1: FIFO head word is valid
- `cfg_ready_in` in 1: fabric accepts the head word this cycle
- `cfg_tile_out` out 16: head word tile id
- `cfg_feature_out` out 8: head word feature id
- `cfg_reg_out` out 8: head word register id
- `cfg_data_out` out 32: head word data
- `config_done_out` out 1: end of configuration detected
- `overflow_out` out 1: sticky; a word was dropped
- `write_count_out` out 16: number of words accepted into the FIFO; saturates at 0xFFFF

## Operation
- Input stage: the pair is registered every cycle. A registered address ≠ 0 is a write request.
- Push: a write request enters the FIFO on the next edge if the FIFO is not full, or if it is full but a pop happens on the same edge.
- Drop: otherwise the word is dropped and `overflow_out` is set. It stays 1 until reset. `write_count_out` does not increment on a drop.
- Pop: when `cfg_valid_out & cfg_ready_in`.
- Output ordering: `cfg_*` outputs show the FIFO head in arrival order. They hold stable while `cfg_valid_out=1` and `cfg_ready_in=0`.
- Done FSM states: IDLE (no write seen), LOADING, DONE.
  - IDLE→LOADING on the first accepted push.
  - In LOADING the idle counter clears on every write request and otherwise increments, saturating at `IDLE_TIMEOUT`.
  - LOADING→DONE when the counter equals `IDLE_TIMEOUT` and the FIFO is empty.
  - DONE→LOADING on any new write request; the counter clears.
- `config_done_out` is 1 only in DONE.
- Dropped words still count as write requests for the idle counter.
- The FSM never enters DONE while any word is still buffered.

## Timing
- Reset values:
  - outputs: `cfg_valid_out=0`, `cfg_tile_out`/`cfg_feature_out`/`cfg_reg_out`/`cfg_data_out`=0, `config_done_out=0`, `overflow_out=0`, `write_count_out=0`
  - internal: FIFO empty, FSM IDLE, counter 0, input register 0
- Latency with the FIFO empty: a word sampled at edge k is pushed at edge k+1. `cfg_valid_out` goes 1 after edge k+1.
- Back-to-back words at one per cycle with `cfg_ready_in` held 1: zero drops, one word out per cycle.
- A simultaneous push and pop with the FIFO empty is not possible, because the word is not visible until after the push. Push and pop together at any occupancy leaves the occupancy unchanged.
- `config_done_out` rises IDLE_TIMEOUT+1 edges after the last write request is sampled, provided the FIFO has drained by then.
- Reset asserted mid-operation: on that edge all buffered words are discarded and every output returns to its reset value. Inputs sampled on that edge are ignored.

## Structure
- Shared package `cgra_config_pkg`:
  - address field LSB/MSB constants (tile, feature, register)
  - `CFG_NOP_ADDR` = 0
  - FSM state enum `cfg_rx_state_t` {IDLE, LOADING, DONE}
  - packed struct `cfg_word_t` {tile, feature, reg, data}
- Sub-module `cfg_fifo`: synchronous FIFO of `cfg_word_t`, parameterised by depth, with push/pop/full/empty. It is reusable by the tile-side decoders.

## Test plan
- Reset, then addresses 0x01020003 and 0x05060007 on consecutive cycles with `cfg_ready_in=1` → `cfg_valid_out` 1 for two cycles starting 2 edges after the first. Fields (tile 3, feature 2, reg 1) then (tile 7, feature 6, reg 5) in order. `write_count_out=2`.
- `cfg_ready_in=0`, drive 6 non-zero words back-to-back (FIFO_DEPTH=4) → first 4 retained, 5th and 6th dropped, `overflow_out=1`, `write_count_out=4`. Raising ready drains exactly the first 4 in order.
- After the last write, drive address 0 with ready=1 → `config_done_out` rises exactly 9 edges after the last write was sampled and stays 1.
- Hold ready=0 over the timeout window, then release → `config_done_out` stays 0 until the FIFO empties, then rises.
- In DONE, drive one more write → `config_done_out` falls the next edge and the word is delivered. After 8 further no-op cycles it re-asserts.
- Assert `reset_in` with 3 words buffered → next cycle all outputs are 0 and the FIFO is empty. The following write is delivered normally with `write_count_out=1`.

Source files
------------

// File: rtl/cgra_config_pkg.sv
// cgra_config_pkg: shared config-word field layout, FSM states and decode helper
package cgra_config_pkg;
  localparam int TILE_LSB = 0;
  localparam int TILE_MSB = 15;
  localparam int FEAT_LSB = 16;
  localparam int FEAT_MSB = 23;
  localparam int REG_LSB  = 24;
  localparam int REG_MSB  = 31;
  localparam logic [31:0] CFG_NOP_ADDR = '0;
  typedef enum logic [1:0] {IDLE, LOADING, DONE} cfg_rx_state_t;
  // reg is a keyword, so the register field is reg_id
  typedef struct packed {
    logic [15:0] tile;
    logic [7:0]  feature;
    logic [7:0]  reg_id;
    logic [31:0] data;
  } cfg_word_t;
  function automatic cfg_word_t cfg_decode(input logic [31:0] addr, input logic [31:0] data);
    return '{tile: addr[TILE_MSB:TILE_LSB], feature: addr[FEAT_MSB:FEAT_LSB],
             reg_id: addr[REG_MSB:REG_LSB], data: data};
  endfunction
endpackage

// File: rtl/config_bus_receiver_if.sv
// config_bus_receiver_if: raw config input pair plus decoded valid/ready output bus
interface config_bus_receiver_if;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;
  logic        cfg_valid_out;
  logic        cfg_ready_in;
  logic [15:0] cfg_tile_out;
  logic [7:0]  cfg_feature_out;
  logic [7:0]  cfg_reg_out;
  logic [31:0] cfg_data_out;
  logic        config_done_out;
  logic        overflow_out;
  logic [15:0] write_count_out;
  modport slave (
    input  config_addr_in, config_data_in, cfg_ready_in,
    output cfg_valid_out, cfg_tile_out, cfg_feature_out, cfg_reg_out, cfg_data_out,
           config_done_out, overflow_out, write_count_out
  );
  modport master (
    output config_addr_in, config_data_in, cfg_ready_in,
    input  cfg_valid_out, cfg_tile_out, cfg_feature_out, cfg_reg_out, cfg_data_out,
           config_done_out, overflow_out, write_count_out
  );
endinterface

// File: rtl/cfg_fifo.sv
// cfg_fifo: synchronous FIFO of cfg_word_t; push while full is accepted only with a pop
module cfg_fifo
  import cgra_config_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  cfg_word_t wdata_i,
  output cfg_word_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);
  cfg_word_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // head reads as zero when empty so the bus is quiet after reset and drain
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/config_bus_receiver.sv
// config_bus_receiver: registers, decodes and buffers raw config words for the tile fabric,
// flags dropped words and detects end of configuration after an idle window.
module config_bus_receiver
  import cgra_config_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input logic                  clk_in,
  input logic                  reset_in,
  config_bus_receiver_if.slave bus
);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] T_MAX = CW'(IDLE_TIMEOUT);
  logic [31:0]   addr_q, data_q;
  cfg_rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q;
  logic [15:0]   count_q;
  logic          wr_req, pop, push, full, empty;
  cfg_word_t     head;
  assign wr_req = addr_q != CFG_NOP_ADDR;
  assign pop    = ~empty & bus.cfg_ready_in;
  assign push   = wr_req & (~full | pop);
  cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in), .rst(reset_in), .push_i(push), .pop_i(pop),
    .wdata_i(cfg_decode(addr_q, data_q)), .rdata_o(head), .full_o(full), .empty_o(empty)
  );
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      addr_q     <= '0;
      data_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      addr_q     <= bus.config_addr_in;
      data_q     <= bus.config_data_in;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (wr_req & ~push);
      count_q    <= count_q + 16'(push && count_q != 16'hFFFF);
    end
  end
  // dropped words still reset the idle window; DONE waits for the FIFO to drain
  always_comb begin
    cnt_d   = (wr_req || state_q == IDLE) ? '0 : (cnt_q == T_MAX) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q == IDLE ? (push ? LOADING : IDLE)
            : wr_req ? LOADING
            : (cnt_d == T_MAX && empty) ? DONE : state_q;
  end
  assign bus.cfg_valid_out   = ~empty;
  assign bus.cfg_tile_out    = head.tile;
  assign bus.cfg_feature_out = head.feature;
  assign bus.cfg_reg_out     = head.reg_id;
  assign bus.cfg_data_out    = head.data;
  assign bus.config_done_out = state_q == DONE;
  assign bus.overflow_out    = overflow_q;
  assign bus.write_count_out = count_q;
endmodule

// File: tb/tb_config_bus_receiver.sv
// tb_config_bus_receiver: scoreboard bench; retained words are queued when driven and
// compared as the fabric accepts them, with direct checks on latency, drops and done timing.
module tb_config_bus_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  config_bus_receiver_if bus();
  config_bus_receiver #(.FIFO_DEPTH(4), .IDLE_TIMEOUT(8)) dut (
    .clk_in(clk), .reset_in(rst), .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit keep);
    bus.config_addr_in = a;
    bus.config_data_in = d;
    if (keep) exp_q.push_back({a[15:0], a[23:16], a[31:24], d});
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 64'(bus.cfg_valid_out), 64'd0);
    check({tag, "_fields"}, {bus.cfg_tile_out, bus.cfg_feature_out, bus.cfg_reg_out, bus.cfg_data_out}, 64'd0);
    check({tag, "_done"}, 64'(bus.config_done_out), 64'd0);
    check({tag, "_ovf"}, 64'(bus.overflow_out), 64'd0);
    check({tag, "_count"}, 64'(bus.write_count_out), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.cfg_valid_out && bus.cfg_ready_in) begin
      if (exp_q.size() == 0) check("sb_extra", 64'(exp_q.size()), 64'd1);
      else check("sb_word", {bus.cfg_tile_out, bus.cfg_feature_out, bus.cfg_reg_out, bus.cfg_data_out}, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int guard;
    bus.config_addr_in = '0;
    bus.config_data_in = '0;
    bus.cfg_ready_in   = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    check_quiet("rst");
    bus.cfg_ready_in = 1'b1;
    drive(32'h01020003, 32'h000000A1, 1);
    cyc();
    check("lat_before_push", 64'(bus.cfg_valid_out), 64'd0);
    drive(32'h05060007, 32'h000000B2, 1);
    cyc();
    check("lat_after_push", 64'(bus.cfg_valid_out), 64'd1);
    drive('0, 32'hDEAD, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 1) check("valid_second", 64'(bus.cfg_valid_out), 64'd1);
      if (i == 2) check("valid_gone", 64'(bus.cfg_valid_out), 64'd0);
      check($sformatf("done_edge%0d", i), 64'(bus.config_done_out), 64'(i == 9));
    end
    check("count_two", 64'(bus.write_count_out), 64'd2);
    repeat (2) cyc();
    check("done_stays", 64'(bus.config_done_out), 64'd1);
    drive(32'h0A0B000C, 32'h000000C3, 1);
    cyc();
    check("done_hold_on_sample", 64'(bus.config_done_out), 64'd1);
    drive('0, '0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check($sformatf("redone_edge%0d", i), 64'(bus.config_done_out), 64'(i == 9));
    end
    check("count_three", 64'(bus.write_count_out), 64'd3);
    check("sb_empty_1", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.cfg_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive({8'(i + 1), 8'(i + 16), 16'(i + 256)}, 32'(i * 17 + 4096), i < 4);
      cyc();
    end
    drive('0, '0, 0);
    repeat (2) cyc();
    check("ovf_set", 64'(bus.overflow_out), 64'd1);
    check("ovf_count", 64'(bus.write_count_out), 64'd4);
    check("ovf_valid", 64'(bus.cfg_valid_out), 64'd1);
    repeat (12) cyc();
    check("done_blocked_full", 64'(bus.config_done_out), 64'd0);
    check("ovf_sticky", 64'(bus.overflow_out), 64'd1);
    bus.cfg_ready_in = 1'b1;
    guard = 0;
    while (bus.cfg_valid_out && guard < 10) begin
      check("done_while_draining", 64'(bus.config_done_out), 64'd0);
      cyc();
      guard++;
    end
    check("drain_len", 64'(guard), 64'd4);
    check("sb_empty_2", 64'(exp_q.size()), 64'd0);
    guard = 0;
    while (!bus.config_done_out && guard < 3) begin
      cyc();
      guard++;
    end
    check("done_after_drain", 64'(bus.config_done_out), 64'd1);
    bus.cfg_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive({8'(i + 9), 8'(i + 32), 16'(i + 512)}, 32'(i + 8192), 1);
      cyc();
    end
    drive('0, '0, 0);
    repeat (2) cyc();
    check("buffered_valid", 64'(bus.cfg_valid_out), 64'd1);
    rst = 1'b1;
    drive(32'h0F0F0F0F, 32'h1, 0);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    drive('0, '0, 0);
    check_quiet("midrst");
    cyc();
    check("rst_ignores_input_valid", 64'(bus.cfg_valid_out), 64'd0);
    check("rst_ignores_input_count", 64'(bus.write_count_out), 64'd0);
    bus.cfg_ready_in = 1'b1;
    drive(32'h11223344, 32'h00000055, 1);
    cyc();
    drive('0, '0, 0);
    cyc();
    check("post_rst_valid", 64'(bus.cfg_valid_out), 64'd1);
    cyc();
    check("post_rst_count", 64'(bus.write_count_out), 64'd1);
    check("post_rst_drained", 64'(bus.cfg_valid_out), 64'd0);
    repeat (2) cyc();
    check("sb_empty_end", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
